// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the unified instruction/data memory of the multicycle core.
// Each access runs IDLE -> ACCESS -> WAIT (MEM_LAT cycles, optional) -> DONE.
//
//   state  | meaning
//   IDLE   | no transaction; sample requests and arbitrate
//   ACCESS | drive memory from latched request; owner's gnt pulses
//   WAIT   | memory latency countdown; address held, no write strobe
//   DONE   | owner's done pulses; read data already captured
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 0,
    parameter int FAIR    = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_adr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_done,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_adr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_done,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          owner
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic [7:0] LAT_INIT = MEM_LAT[7:0];
    localparam bit         NO_WAIT  = (MEM_LAT == 0);
    localparam bit         RR       = (FAIR != 0);

    logic [1:0]    state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic          we_q, we_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic          winner;
    logic          capture;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        last_d   = last_q;
        we_d     = we_q;
        adr_d    = adr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        capture  = 1'b0;

        // On a tie, round-robin serves the port that did not go last.
        if (m0_req && m1_req) begin
            winner = RR ? ~last_q : 1'b0;
        end else begin
            winner = m1_req;
        end

        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    state_d = ACCESS;
                    owner_d = winner;
                    last_d  = winner;
                    we_d    = winner ? m1_we    : m0_we;
                    adr_d   = winner ? m1_adr   : m0_adr;
                    wdata_d = winner ? m1_wdata : m0_wdata;
                end
            end
            ACCESS: begin
                if (NO_WAIT) begin
                    state_d = DONE;
                    capture = 1'b1;
                end else begin
                    state_d = WAIT;
                    cnt_d   = LAT_INIT;
                end
            end
            WAIT: begin
                if (cnt_q == 8'd1) begin
                    state_d = DONE;
                    capture = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Read data lands in the owner's register on the last memory cycle.
        if (capture && !we_q) begin
            if (owner_q) begin
                rdata1_d = mem_rdata;
            end else begin
                rdata0_d = mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            we_q     <= 1'b0;
            adr_q    <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            we_q     <= we_d;
            adr_q    <= adr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign m0_gnt    = (state_q == ACCESS) && !owner_q;
    assign m1_gnt    = (state_q == ACCESS) &&  owner_q;
    assign m0_done   = (state_q == DONE)   && !owner_q;
    assign m1_done   = (state_q == DONE)   &&  owner_q;
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;
    assign mem_we    = (state_q == ACCESS) && we_q;
    assign mem_adr   = adr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != IDLE);
    assign owner     = owner_q;

endmodule
